uart_rx_os8: RTL and testbench

Asynchronous serial receiver, 8N1, with 8x oversampling and 3-sample majority voting. It is the receive-side counterpart of the existing `uart_tx` and uses the same `prescale` semantics, so both directions share one baud setting. It sits on the system clock domain and turns the host's serial line into a byte stream with a valid/ready handshake. Command and calibration logic downstream consume that stream.

---
 rtl/uart_rx_os8.sv | 157 +++++++++++++++
 tb/tb_uart_rx_os8.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os8.sv
// 8N1 UART receiver, 8x oversampling with 3-sample majority vote.
// Byte output uses a valid/ready handshake with overrun and frame-error pulses.
`timescale 1ns/1ps
module uart_rx_os8 #(
  parameter int DATA_WIDTH    = 8,
  parameter int PRESCALE_SIZE = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_rxd,
  input  logic [PRESCALE_SIZE-1:0] i_prescale,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_frame_error,
  output logic                     o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  localparam logic [PRESCALE_SIZE-1:0] ONE = 1;
  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  state_e                   state_q;
  logic                     sync1_q;
  logic                     sync2_q;
  logic [1:0]               fill_q;
  logic                     prev_q;
  logic [PRESCALE_SIZE-1:0] pre_q;
  logic [PRESCALE_SIZE-1:0] cnt_q;
  logic [2:0]               phase_q;
  logic [2:0]               bit_q;
  logic [1:0]               smp_q;
  logic [DATA_WIDTH-1:0]    shift_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     valid_q;
  logic                     ferr_q;
  logic                     ovr_q;

  logic rxs;
  logic fall_d;
  logic tick_d;
  logic maj_d;

  assign rxs    = sync2_q;
  assign fall_d = prev_q & ~rxs;
  assign tick_d = (cnt_q == pre_q - ONE);
  assign maj_d  = (smp_q[1] & smp_q[0])
                | (smp_q[1] & rxs)
                | (smp_q[0] & rxs);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      prev_q  <= 1'b0;
      pre_q   <= ONE;
      cnt_q   <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= i_rxd;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      // prev only counts a 1 that really came from the pin after reset
      prev_q  <= fill_q[1] & rxs;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
      if (state_q != S_IDLE) begin
        if (tick_d) begin
          cnt_q   <= '0;
          phase_q <= phase_q + 3'd1;
          if (phase_q == 3'd3) smp_q[1] <= rxs;
          if (phase_q == 3'd4) smp_q[0] <= rxs;
        end else begin
          cnt_q <= cnt_q + ONE;
        end
      end
      unique case (state_q)
        S_IDLE: begin
          if (fall_d) begin
            state_q <= S_START;
            cnt_q   <= '0;
            phase_q <= '0;
            pre_q   <= (i_prescale == '0) ? ONE : i_prescale;
          end
        end
        S_START: begin
          if (tick_d) begin
            if (phase_q == 3'd5 && maj_d) begin
              state_q <= S_IDLE;
            end else if (phase_q == 3'd7) begin
              state_q <= S_DATA;
              bit_q   <= '0;
            end
          end
        end
        S_DATA: begin
          if (tick_d) begin
            if (phase_q == 3'd5) begin
              shift_q <= {maj_d, shift_q[DATA_WIDTH-1:1]};
            end
            if (phase_q == 3'd7) begin
              if (bit_q == LAST_BIT) state_q <= S_STOP;
              else bit_q <= bit_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (tick_d && phase_q == 3'd5) begin
            if (maj_d) begin
              state_q <= S_IDLE;
              if (!valid_q || i_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              state_q <= S_BREAK;
              ferr_q  <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (rxs) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_frame_error = ferr_q;
  assign o_overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_os8.sv
// Bench for uart_rx_os8: directed frames plus random frames
// checked against a frame-level model of the received byte stream.
`timescale 1ns/1ps
module tb_uart_rx_os8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxd;
  logic [15:0] prescale;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        ferr;
  logic        ovr;

  int checks = 0;
  int errors = 0;

  int n_acc = 0;
  int n_vcyc = 0;
  int n_fe = 0;
  int n_ov = 0;
  logic [7:0] got [0:255];

  int b_acc, b_vcyc, b_fe, b_ov;
  logic [7:0] exp_q [$];

  uart_rx_os8 #(.DATA_WIDTH(8), .PRESCALE_SIZE(16)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_rxd        (rxd),
    .i_prescale   (prescale),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_busy       (busy),
    .o_frame_error(ferr),
    .o_overrun    (ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) n_vcyc <= n_vcyc + 1;
    if (valid && ready) begin
      got[n_acc[7:0]] <= data;
      n_acc <= n_acc + 1;
    end
    if (ferr) n_fe <= n_fe + 1;
    if (ovr) n_ov <= n_ov + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic snap();
    b_acc  = n_acc;
    b_vcyc = n_vcyc;
    b_fe   = n_fe;
    b_ov   = n_ov;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame on the pin: start, 8 data LSB first, stop; 8*P cycles per bit.
  // gs forces a single low cycle at that step; nstep<0 means the whole frame.
  task automatic send(input logic [7:0] b, input logic stop, input int p,
                      input int gs, input int nstep);
    int e;
    int n;
    logic [9:0] bits;
    e = (p == 0) ? 1 : p;
    n = (nstep < 0) ? 80 * e : nstep;
    bits = {stop, b, 1'b0};
    prescale = 16'(p);
    for (int j = 0; j < n; j++) begin
      rxd = (j == gs) ? 1'b0 : bits[j / (8 * e)];
      step();
    end
  endtask

  initial begin
    int p;
    int nf;
    logic [7:0] b;

    rst_n = 1'b0;
    rxd = 1'b1;
    ready = 1'b1;
    prescale = 16'd4;
    wait_n(3);
    chk("reset_outputs", {data, valid, busy, ferr, ovr}, 32'h0);
    rst_n = 1'b1;
    wait_n(8);

    // single byte, ready high
    snap();
    send(8'h55, 1'b1, 4, -1, -1);
    wait_n(6);
    chk("b55_count", n_acc - b_acc, 1);
    chk("b55_data", got[b_acc[7:0]], 8'h55);
    chk("b55_valid_cycles", n_vcyc - b_vcyc, 1);
    chk("b55_ferr", n_fe - b_fe, 0);
    chk("b55_ovr", n_ov - b_ov, 0);

    // back-to-back frames
    snap();
    send(8'hA3, 1'b1, 4, -1, -1);
    send(8'h0F, 1'b1, 4, -1, -1);
    wait_n(6);
    chk("b2b_count", n_acc - b_acc, 2);
    chk("b2b_first", got[b_acc[7:0]], 8'hA3);
    chk("b2b_second", got[8'(b_acc + 1)], 8'h0F);

    // short low glitch: false start
    snap();
    rxd = 1'b0;
    wait_n(8);
    rxd = 1'b1;
    chk("glitch_busy_rise", busy, 1'b1);
    wait_n(4 * 4 + 6);
    chk("glitch_busy_fall", busy, 1'b0);
    wait_n(40);
    chk("glitch_no_valid", n_acc - b_acc, 0);

    // one-cycle low at phase 4 of data bit 3
    snap();
    send(8'hFF, 1'b1, 4, 37 * 4, -1);
    wait_n(6);
    chk("vote_count", n_acc - b_acc, 1);
    chk("vote_data", got[b_acc[7:0]], 8'hFF);

    // bad stop bit, then break for 20 bit times
    snap();
    send(8'h3C, 1'b0, 4, -1, -1);
    wait_n(160 * 4);
    chk("brk_busy_held", busy, 1'b1);
    chk("brk_ferr_once", n_fe - b_fe, 1);
    chk("brk_no_valid", n_acc - b_acc, 0);
    rxd = 1'b1;
    wait_n(4);
    chk("brk_idle", busy, 1'b0);
    wait_n(20);

    // overrun with consumer stalled
    snap();
    ready = 1'b0;
    send(8'h11, 1'b1, 4, -1, -1);
    wait_n(4);
    send(8'h22, 1'b1, 4, -1, -1);
    wait_n(6);
    chk("ovr_data_held", data, 8'h11);
    chk("ovr_valid_held", valid, 1'b1);
    chk("ovr_pulse", n_ov - b_ov, 1);
    ready = 1'b1;
    @(negedge clk);
    #1;
    chk("ovr_valid_before_hs", valid, 1'b1);
    step();
    chk("ovr_valid_after_hs", valid, 1'b0);
    chk("ovr_accepted", got[b_acc[7:0]], 8'h11);

    // reset mid-frame, release with the line low
    snap();
    send(8'h7E, 1'b1, 4, -1, 40 * 4);
    rxd = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {data, valid, busy, ferr, ovr}, 32'h0);
    wait_n(3);
    rst_n = 1'b1;
    wait_n(5 * 4);
    chk("rst_low_no_start", busy, 1'b0);
    rxd = 1'b1;
    wait_n(16);
    send(8'h7E, 1'b1, 4, -1, -1);
    wait_n(6);
    chk("rst_next_count", n_acc - b_acc, 1);
    chk("rst_next_data", got[b_acc[7:0]], 8'h7E);

    // random frames, random prescale (0 behaves as 1) and idle gaps
    snap();
    exp_q.delete();
    nf = 8;
    for (int k = 0; k < nf; k++) begin
      p = $urandom_range(0, 5);
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b, 1'b1, p, -1, -1);
      wait_n($urandom_range(0, 20));
    end
    wait_n(6);
    chk("rand_count", n_acc - b_acc, nf);
    for (int k = 0; k < nf; k++) begin
      chk($sformatf("rand_byte%0d", k), got[8'(b_acc + k)], exp_q[k]);
    end
    chk("rand_ferr", n_fe - b_fe, 0);
    chk("rand_ovr", n_ov - b_ov, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
